// File: rtl/dmem_responder_pkg.sv
// =============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared request/state types and lane-mask helper for dmem_responder.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package dmem_responder_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_t;

    // Expands a 4-bit byte-lane mask into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// =============================================================================
// Module   : dmem_responder_if
// Brief    : Data-memory request/response bus between the MEM stage and responder.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface dmem_responder_if;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        oor_err;

    modport master (
        output dmem_addr,
        output dmem_rmask,
        output dmem_wmask,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_resp,
        input  oor_err
    );

    modport slave (
        input  dmem_addr,
        input  dmem_rmask,
        input  dmem_wmask,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_resp,
        output oor_err
    );

endinterface

`default_nettype wire

// File: rtl/dmem_responder_sram.sv
// =============================================================================
// Module   : dmem_sram
// Brief    : 2^ADDR_WIDTH x 32 scratchpad, per-byte write enables, read-before-write.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_sram #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  i_en,
    input  wire logic [ADDR_WIDTH-1:0] i_idx,
    input  wire logic [3:0]            i_we,
    input  wire logic [31:0]           i_wdata,
    output logic      [31:0]           o_rdata
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    // One byte-wide array per lane keeps each lane's write enable independent.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] r_mem [c_depth];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_en) begin
                r_q <= r_mem[i_idx];
                if (i_we[b]) begin
                    r_mem[i_idx] <= i_wdata[8*b +: 8];
                end
            end
        end

        assign o_rdata[8*b +: 8] = r_q;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// =============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder backed by an on-chip scratchpad.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h1ECE_B000,
    parameter int          LATENCY    = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dmem_responder_if.slave  bus
);

    localparam int                 c_cnt_w    = $clog2(LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    dmem_req_t             w_req;
    logic                  w_req_valid;
    logic                  w_accept;
    logic [30:0]           w_word_diff;
    logic                  w_oor;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_we;
    logic [31:0]           w_sram_q;
    logic                  w_unused_lsbs;

    dmem_resp_state_t      r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_resp;
    logic                  r_oor_err;
    logic [3:0]            r_rmask;

    assign w_req = '{addr:  bus.dmem_addr,
                     rmask: bus.dmem_rmask,
                     wmask: bus.dmem_wmask,
                     wdata: bus.dmem_wdata};

    assign w_req_valid   = |(w_req.rmask | w_req.wmask);
    assign w_accept      = w_req_valid && (r_state != WAIT);
    assign w_unused_lsbs = ^w_req.addr[1:0];

    // Word-granular subtraction; bit 30 flags an address below the base.
    assign w_word_diff = {1'b0, w_req.addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign w_oor       = w_word_diff[30] | (|(w_word_diff[29:0] >> ADDR_WIDTH));
    assign w_idx       = w_word_diff[ADDR_WIDTH-1:0];
    assign w_we        = (w_accept && !w_oor) ? w_req.wmask : 4'b0000;

    dmem_sram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_idx   (w_idx),
        .i_we    (w_we),
        .i_wdata (w_req.wdata),
        .o_rdata (w_sram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_resp    <= 1'b0;
            r_oor_err <= 1'b0;
            r_rmask   <= 4'b0000;
        end else begin
            r_resp <= 1'b0;
            unique case (r_state)
                WAIT: begin
                    if (r_cnt == c_cnt_one) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    if (w_accept) begin
                        // Out-of-range reads return zero by clearing the lane mask.
                        r_rmask <= w_oor ? 4'b0000 : w_req.rmask;
                        if (w_oor) begin
                            r_oor_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_cnt_load;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Both operands are registers that change only at acceptance, so rdata holds between responses.
    assign bus.dmem_rdata = w_sram_q & lane_mask(r_rmask);
    assign bus.dmem_resp  = r_resp;
    assign bus.oor_err    = r_oor_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// =============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed bench for dmem_responder at LATENCY 1, 4 and 8.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam logic [31:0] B = 32'h1ECE_B000;

    logic clk = 1'b0;
    logic rst_n;
    logic rst8_n;

    always #5 clk = ~clk;

    dmem_responder_if if1 ();
    dmem_responder_if if4 ();
    dmem_responder_if if8 ();

    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(B), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(B), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave));
    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(B), .LATENCY(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .bus(if8.slave));

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_oor;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [3:0] r, input logic [3:0] w,
                                input logic [31:0] d, input logic [31:0] er, input logic eo);
        vec_t v;
        v.addr = a; v.rmask = r; v.wmask = w; v.wdata = d; v.exp_rdata = er; v.exp_oor = eo;
        return v;
    endfunction

    task automatic drive(input int w, input logic [31:0] a, input logic [3:0] r,
                         input logic [3:0] wm, input logic [31:0] d);
        case (w)
            1: begin if1.dmem_addr = a; if1.dmem_rmask = r; if1.dmem_wmask = wm; if1.dmem_wdata = d; end
            4: begin if4.dmem_addr = a; if4.dmem_rmask = r; if4.dmem_wmask = wm; if4.dmem_wdata = d; end
            default: begin if8.dmem_addr = a; if8.dmem_rmask = r; if8.dmem_wmask = wm; if8.dmem_wdata = d; end
        endcase
    endtask

    // {oor_err, dmem_resp, dmem_rdata}
    function automatic logic [33:0] get(input int w);
        case (w)
            1:       return {if1.oor_err, if1.dmem_resp, if1.dmem_rdata};
            4:       return {if4.oor_err, if4.dmem_resp, if4.dmem_rdata};
            default: return {if8.oor_err, if8.dmem_resp, if8.dmem_rdata};
        endcase
    endfunction

    task automatic lat_op(input int w, input int lat, input string name,
                          input logic [31:0] a, input logic [3:0] r, input logic [3:0] wm,
                          input logic [31:0] d, input logic [31:0] er, input logic eo);
        int          early = 0;
        logic [33:0] o = '0;
        drive(w, a, r, wm, d);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1) drive(w, 32'h0, 4'h0, 4'h0, 32'h0);
            o = get(w);
            if (k < lat) early += int'(o[32]);
        end
        check({name, " resp"}, {31'b0, o[32]}, 32'd1);
        check({name, " rdata"}, o[31:0], er);
        check({name, " oor"}, {31'b0, o[33]}, {31'b0, eo});
        check({name, " early"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        o = get(w);
        check({name, " pulse"}, {31'b0, o[32]}, 32'd0);
    endtask

    initial begin
        logic [33:0] o;
        int          early;

        rst_n  = 1'b0;
        rst8_n = 1'b0;
        drive(1, 32'h0, 4'h0, 4'h0, 32'h0);
        drive(4, 32'h0, 4'h0, 4'h0, 32'h0);
        drive(8, 32'h0, 4'h0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        o = get(1);
        check("reset resp", {31'b0, o[32]}, 32'd0);
        check("reset rdata", o[31:0], 32'd0);
        check("reset oor", {31'b0, o[33]}, 32'd0);
        rst_n  = 1'b1;
        rst8_n = 1'b1;
        @(posedge clk); #1;

        // LATENCY=1 stream, every request issued in the previous response cycle.
        vecs.push_back(mk(B, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0));
        vecs.push_back(mk(B, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(B + 32'(4*k), 4'h0, 4'hF, 32'hC0DE0000 + 32'(k), 32'h0, 1'b0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(B + 32'(4*k), 4'hF, 4'h0, 32'h0, 32'hC0DE0000 + 32'(k), 1'b0));
        vecs.push_back(mk(B + 32'd36, 4'h0, 4'hF, 32'h7, 32'h0, 1'b0));
        vecs.push_back(mk(B + 32'd36, 4'hF, 4'hF, 32'h5, 32'h7, 1'b0));
        vecs.push_back(mk(B + 32'd36, 4'hF, 4'h0, 32'h0, 32'h5, 1'b0));
        vecs.push_back(mk(B + 32'd4, 4'b1001, 4'h0, 32'h0, 32'hC0000001, 1'b0));
        vecs.push_back(mk(B + 32'd6, 4'b1100, 4'h0, 32'h0, 32'hC0DE0000, 1'b0));
        vecs.push_back(mk(B + 32'd4092, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0));
        vecs.push_back(mk(B - 32'd4, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1));
        vecs.push_back(mk(B + 32'd4092, 4'hF, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b1));
        vecs.push_back(mk(B + 32'd4096, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(B + 32'd4096, 4'h0, 4'hF, 32'h12345678, 32'h0, 1'b1));
        vecs.push_back(mk(B, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1, vecs[i].addr, vecs[i].rmask, vecs[i].wmask, vecs[i].wdata);
            @(posedge clk); #1;
            o = get(1);
            check($sformatf("v%0d resp", i), {31'b0, o[32]}, 32'd1);
            check($sformatf("v%0d rdata", i), o[31:0], vecs[i].exp_rdata);
            check($sformatf("v%0d oor", i), {31'b0, o[33]}, {31'b0, vecs[i].exp_oor});
        end
        drive(1, 32'h0, 4'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        o = get(1);
        check("l1 idle resp", {31'b0, o[32]}, 32'd0);
        check("l1 rdata hold", o[31:0], 32'hDEADBEEF);
        check("l1 oor sticky", {31'b0, o[33]}, 32'd1);

        // LATENCY=4 byte lanes
        lat_op(4, 4, "l4 init", B, 4'h0, 4'hF, 32'h11223344, 32'h0, 1'b0);
        lat_op(4, 4, "l4 wbyte", B, 4'h0, 4'b0010, 32'h0000AB00, 32'h0, 1'b0);
        lat_op(4, 4, "l4 rlanes", B, 4'b0110, 4'h0, 32'h0, 32'h0022AB00, 1'b0);

        // LATENCY=8, reset while waiting
        lat_op(8, 8, "l8 oor", B - 32'd4, 4'h0, 4'hF, 32'h0, 32'h0, 1'b1);
        lat_op(8, 8, "l8 w", B + 32'd8, 4'h0, 4'hF, 32'h01020304, 32'h0, 1'b1);
        lat_op(8, 8, "l8 r", B + 32'd8, 4'hF, 4'h0, 32'h0, 32'h01020304, 1'b1);
        drive(8, B + 32'd8, 4'h0, 4'hF, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(8, 32'h0, 4'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b0;
        #1;
        o = get(8);
        check("rst8 resp", {31'b0, o[32]}, 32'd0);
        check("rst8 rdata", o[31:0], 32'd0);
        check("rst8 oor", {31'b0, o[33]}, 32'd0);
        @(posedge clk); #1;
        rst8_n = 1'b1;
        early = 0;
        repeat (12) begin
            @(posedge clk); #1;
            o = get(8);
            early += int'(o[32]);
        end
        check("rst8 dropped resp", 32'(early), 32'd0);
        lat_op(8, 8, "l8 after rst", B + 32'd8, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port: it accepts the MEM stage's `dmem_addr`/`rmask`/`wmask`/`wdata` requests and services them from a byte-enabled on-chip scratchpad. After a fixed, parameterized latency it returns `dmem_rdata` together with a one-cycle `dmem_resp` pulse. It sits outside the core, closing the loop on the `req_dmem_resp` handshake the pipeline waits on, and serves as the synthesizable data memory for FPGA and regression builds.

## Interface
- `ADDR_WIDTH`, 10: word-index bits; capacity is 2^ADDR_WIDTH words (default 4 KiB).
- `BASE_ADDR`, 32'h1ECE_B000: byte address of word 0; must be 4-byte aligned.
- `LATENCY`, 1: cycles from the acceptance edge to `dmem_resp` high; legal range 1..15.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `dmem_addr` input 32: request byte address. Bits [1:0] are ignored because the masks are already lane-shifted.
- `dmem_rmask` input 4: read byte-lane mask. Nonzero means a read request.
- `dmem_wmask` input 4: write byte-lane mask. Nonzero means a write request.
- `dmem_wdata` input 32: write data, already lane-aligned.
- `dmem_rdata` output 32: read data, valid in the `dmem_resp` cycle. Reset value 0.
- `dmem_resp` output 1: one-cycle completion pulse. Reset value 0.
- `oor_err` output 1: sticky flag, set on any out-of-range request. Reset value 0.

## Operation
- **States** (`dmem_resp_state_t`): IDLE, WAIT, RESP. Reset enters IDLE.
- **Request:** a request is present when `(dmem_rmask | dmem_wmask) != 0`.
- **Acceptance:** a request is accepted at the edge ending any cycle spent in IDLE or RESP while a request is present. On acceptance:
  - Latch addr, rmask and wmask.
  - Perform the write into the array at this edge, byte lanes per `wmask`.
  - Read the pre-write word into the rdata register, masked: lanes not in `rmask` read as 0.
- **Transitions:**
  - Accept with LATENCY=1: go to RESP.
  - Accept with LATENCY>1: go to WAIT, with a down-counter loaded to LATENCY-1.
  - WAIT: decrement each cycle; go to RESP when the counter reaches 1.
  - RESP with no new request: go to IDLE.
  - RESP with a new request: accept it and repeat the accept rule. This gives back-to-back throughput of one request per LATENCY cycles.
- **Inputs after acceptance:** ignored while in WAIT. The pipeline may hold or drop them.
- **rmask and wmask both nonzero:** treated as a combined access. The write is performed, and rdata returns the pre-write bytes under `rmask`.
- **Word index:** `(dmem_addr - BASE_ADDR) >> 2`. The request is out of range if the subtraction underflows or the index is ≥ 2^ADDR_WIDTH. An out-of-range request:
  - drops the write,
  - returns rdata 0,
  - still produces `dmem_resp`,
  - sets `oor_err`.
- **`dmem_rdata` outside RESP:** holds its last value. Consumers must sample it only when `dmem_resp` is high.
- **Reset mid-operation:** asserting `rst_n` low immediately forces IDLE, `dmem_resp`=0, `dmem_rdata`=0, counter=0 and `oor_err`=0, and drops any pending response. A write already committed at its acceptance edge stays committed. Array contents are not reset and persist across reset.
- **Cancellation:** none. A pipeline flush must still wait for the outstanding `dmem_resp`.

## Timing
- Request present in cycle N → `dmem_resp` high in cycle N+LATENCY, for exactly one cycle.
- Write visibility: a read accepted in the RESP cycle of a write to the same word returns the new data.
- Maximum throughput: one request per LATENCY cycles, with no idle gap required.
- `dmem_resp`, `dmem_rdata` and `oor_err` are registered outputs with no combinational path from the inputs.
- Counter width is `$clog2(LATENCY+1)`. It never underflows; WAIT is never entered when LATENCY=1.

## Structure
- Add to `rv32i_types`:
  - `dmem_req_t`: packed struct of addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0].
  - `dmem_resp_state_t`: enum for IDLE/WAIT/RESP.
- Sub-module `dmem_sram`: 2^ADDR_WIDTH×32 array with per-byte write enables, one synchronous read-before-write port, and no reset on the array.
- Top level contains the FSM, latency counter, range check, masking and `oor_err`.

## Test plan
- **Basic write then read, LATENCY=1:** write `wmask`=4'hF, addr `BASE_ADDR`, data 32'hDEADBEEF; then read `rmask`=4'hF at the same address → `dmem_resp` one cycle after each request, and the read returns 32'hDEADBEEF.
- **Byte lanes and LATENCY=4:** write 32'h0000AB00 with `wmask`=4'b0010 over an existing word 32'h11223344; read with `rmask`=4'b0110 → `dmem_resp` exactly 4 cycles after the request, rdata 32'h0022AB00.
- **Back-to-back, LATENCY=1:** read issued in every RESP cycle for 8 consecutive words → 8 consecutive `dmem_resp` pulses with correct data each cycle.
- **Out of range:** write to `BASE_ADDR`-4, then read at `BASE_ADDR`+4·2^ADDR_WIDTH → both responses occur; rdata 0; `oor_err` goes high and stays high; the array is unchanged.
- **Reset in WAIT, LATENCY=8:** pulse `rst_n` low 3 cycles after accepting a write → no `dmem_resp`; all outputs 0 during reset; a subsequent read shows the write committed.
- **Combined access:** `rmask`=4'hF and `wmask`=4'hF with data 32'h5, over old word 32'h7 → rdata 32'h7, and a later read returns 32'h5.
